// File: rtl/ifm_pkg.sv
// rtl/ifm_pkg.sv - shared state encoding and default sizes for the IFM read fetcher
//
// Purpose: common definitions imported by ifm_fetch_fifo and ifm_read_fetcher.
//   ifm_state_e    : fetcher FSM states (IDLE, RUN, DRAIN)
//   IFM_*          : default DATA_WIDTH / ADDR_WIDTH / FIFO_DEPTH
//   ifm_cnt_width  : width of an occupancy counter able to hold 0..depth
package ifm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ifm_state_e;

  localparam int IFM_DATA_WIDTH = 32;
  localparam int IFM_ADDR_WIDTH = 20;
  localparam int IFM_FIFO_DEPTH = 4;

  function automatic int ifm_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifm_fetch_fifo.sv
// rtl/ifm_fetch_fifo.sv - first-word-fall-through output buffer for the IFM fetcher
//
// Purpose: synchronous FWFT FIFO; the head entry is visible on head_data_o
// whenever count_o is non-zero.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the buffer)
//   push_i        : write push_data_i at the tail
//   pop_i         : drop the head entry (ignored when empty)
//   head_data_o   : current head entry
//   count_o       : occupancy, 0..DEPTH
module ifm_fetch_fifo
  import ifm_pkg::*;
#(
  parameter int DATA_WIDTH = IFM_DATA_WIDTH,
  parameter int DEPTH      = IFM_FIFO_DEPTH,
  localparam int CW        = ifm_cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [CW-1:0]         count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A full buffer may still accept a push when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/ifm_read_fetcher.sv
// rtl/ifm_read_fetcher.sv - burst reader from IFM BRAM to a valid/ready word stream
//
// Purpose: on start, reads num_words consecutive words from the IFM BRAM
// starting at the word-aligned base_addr and streams them out in order.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : one-cycle burst request, honoured only when idle
//   base_addr, num_words     : burst byte address and length (0 allowed)
//   bram_rd_addr             : registered byte address to the BRAM read port
//   bram_rd_data             : BRAM data, valid the cycle after the address
//   m_valid/m_ready/m_data   : output word handshake
//   m_last                   : marks the final word of the burst
//   busy                     : burst in progress
//   done                     : one-cycle pulse when the burst completes
module ifm_read_fetcher
  import ifm_pkg::*;
#(
  parameter int DATA_WIDTH = IFM_DATA_WIDTH,
  parameter int ADDR_WIDTH = IFM_ADDR_WIDTH,
  parameter int FIFO_DEPTH = IFM_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_words,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = ifm_cnt_width(FIFO_DEPTH);

  ifm_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, nwords_q, rd_cnt_q, beat_cnt_q;
  // p1_q: address on the BRAM port this cycle; p2_q: its data is on bram_rd_data.
  logic                  p1_q, p2_q, done_q;

  logic                  first_issue, run_issue, zero_done, finish;
  logic                  pop, last_beat, credit_ok;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CW:0]           occ;

  assign m_valid   = (fifo_count != '0);
  assign pop       = m_valid && m_ready;
  assign last_beat = (beat_cnt_q == (nwords_q - ADDR_WIDTH'(1)));

  // Every word already buffered or still in the BRAM pipeline holds a slot;
  // a pop this cycle frees one, which keeps the stream bubble-free.
  assign occ       = {1'b0, fifo_count} + (CW+1)'(p1_q) + (CW+1)'(p2_q) - (CW+1)'(pop);
  assign credit_ok = (occ < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    first_issue = 1'b0;
    run_issue   = 1'b0;
    zero_done   = 1'b0;
    finish      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            zero_done = 1'b1;
          end else begin
            // Buffer is empty here, so the first read needs no credit check.
            first_issue = 1'b1;
            state_d     = (num_words == ADDR_WIDTH'(1)) ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (credit_ok) begin
          run_issue = 1'b1;
          if (rd_cnt_q + ADDR_WIDTH'(1) == nwords_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && last_beat) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      nwords_q   <= '0;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
      p1_q       <= 1'b0;
      p2_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      p1_q   <= first_issue || run_issue;
      p2_q   <= p1_q;
      done_q <= zero_done || finish;
      if (first_issue) begin
        addr_q     <= base_addr & ~ADDR_WIDTH'(3);
        nwords_q   <= num_words;
        rd_cnt_q   <= ADDR_WIDTH'(1);
        beat_cnt_q <= '0;
      end else begin
        if (run_issue) begin
          addr_q   <= addr_q + ADDR_WIDTH'(4);
          rd_cnt_q <= rd_cnt_q + ADDR_WIDTH'(1);
        end
        if (pop) begin
          beat_cnt_q <= beat_cnt_q + ADDR_WIDTH'(1);
        end
      end
    end
  end

  ifm_fetch_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (p2_q),
    .push_data_i (bram_rd_data),
    .pop_i       (pop),
    .head_data_o (fifo_head),
    .count_o     (fifo_count)
  );

  assign bram_rd_addr = addr_q;
  // Gated so stale buffer contents never show while the stream is idle.
  assign m_data       = m_valid ? fifo_head : '0;
  assign m_last       = m_valid && last_beat;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_ifm_read_fetcher.sv
// tb/tb_ifm_read_fetcher.sv - self-checking bench for ifm_read_fetcher
module tb_ifm_read_fetcher;

  localparam int DW    = 32;
  localparam int AW    = 20;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_words = '0;
  logic [AW-1:0] bram_rd_addr;
  logic [DW-1:0] bram_rd_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  ifm_read_fetcher #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM: word i holds value i, one cycle read latency.
  always @(posedge clk) bram_rd_data <= DW'(bram_rd_addr >> 2);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            beat_cyc[$];
  logic [DW-1:0] beat_data[$];
  int            done_cyc[$];
  logic [AW-1:0] addr_log[$];
  bit            rnd_mode = 1'b0;

  task automatic clear_logs();
    beat_cyc.delete();
    beat_data.delete();
    done_cyc.delete();
    addr_log.delete();
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Behavioural model and per-cycle compare.
  initial begin : cmp
    bit            model_busy, done_due, chk_reset, stalled, busy_next, done_next;
    logic [DW-1:0] st_data;
    logic          st_last;
    logic [AW-1:0] prev_addr, a;
    int            outstanding;
    beat_t         b;
    model_busy = 0; done_due = 0; chk_reset = 0; stalled = 0;
    st_data = '0; st_last = 0; prev_addr = '0; outstanding = 0;
    forever begin
      @(negedge clk);
      busy_next = model_busy;
      done_next = 0;
      if (chk_reset) begin
        chk("rst_addr", bram_rd_addr, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk_reset = 0;
      end
      chk("done", done, done_due);
      if (done === 1'b1) done_cyc.push_back(cyc);
      chk("busy", busy, model_busy);
      if (bram_rd_addr !== prev_addr) begin
        addr_log.push_back(bram_rd_addr);
        outstanding++;
        if (exp_addr_q.size() == 0) chk("unexpected_read", 1, 0);
        else chk("rd_addr", bram_rd_addr, exp_addr_q.pop_front());
        chk("credit", outstanding <= DEPTH, 1);
      end
      prev_addr = bram_rd_addr;
      if (rst) begin
        exp_q.delete();
        exp_addr_q.delete();
        outstanding = 0;
        model_busy = 0;
        done_due = 0;
        prev_addr = '0;
        stalled = 0;
        chk_reset = 1;
      end else begin
        if (stalled) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, st_data);
          chk("stall_last", m_last, st_last);
        end
        if (m_valid && exp_q.size() == 0) chk("spurious_valid", 1, 0);
        if (m_valid && m_ready && exp_q.size() != 0) begin
          b = exp_q.pop_front();
          chk("beat_data", m_data, b.data);
          chk("beat_last", m_last, b.last);
          outstanding--;
          beat_cyc.push_back(cyc);
          beat_data.push_back(m_data);
          if (b.last) begin
            done_next = 1;
            busy_next = 0;
          end
        end
        if (start && !model_busy) begin
          if (num_words == '0) begin
            done_next = 1;
          end else begin
            busy_next = 1;
            for (int k = 0; k < int'(num_words); k++) begin
              a = {base_addr[AW-1:2], 2'b00} + AW'(4 * k);
              exp_addr_q.push_back(a);
              b.data = DW'(a >> 2);
              b.last = (k == int'(num_words) - 1);
              exp_q.push_back(b);
            end
          end
        end
        stalled = m_valid && !m_ready;
        st_data = m_data;
        st_last = m_last;
        done_due = done_next;
        model_busy = busy_next;
      end
    end
  end

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] n, output int t);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b;
    num_words = n;
    t = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int i;
    i = 0;
    while (done !== 1'b1 && i < bound) begin
      @(negedge clk);
      i++;
    end
    if (done !== 1'b1) chk({name, "_timeout"}, 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : directed
    int t, t2, i;
    logic [AW-1:0] d_addr[4];
    logic [DW-1:0] d_data[4];
    d_addr = '{20'hFFFF8, 20'hFFFFC, 20'h00000, 20'h00004};
    d_data = '{32'h3FFFE, 32'h3FFFF, 32'h0, 32'h1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Straight 8-word burst, consumer always ready.
    clear_logs();
    pulse_start(20'h40, 20'd8, t);
    wait_done(60, "A");
    chk("A_nbeats", beat_cyc.size(), 8);
    chk("A_naddr", addr_log.size(), 8);
    if (beat_cyc.size() == 8 && addr_log.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("A_beat_cyc", beat_cyc[k], t + 3 + k);
        chk("A_data", beat_data[k], 16 + k);
        chk("A_addr", addr_log[k], 'h40 + 4 * k);
      end
    end
    chk("A_done_cyc", done_cyc.size() == 1 ? done_cyc[0] : -1, t + 11);

    // Zero-length burst.
    clear_logs();
    pulse_start(20'h123, 20'd0, t);
    repeat (4) @(posedge clk);
    #1;
    chk("B_done_cyc", done_cyc.size() == 1 ? done_cyc[0] : -1, t + 1);
    chk("B_nbeats", beat_cyc.size(), 0);
    chk("B_naddr", addr_log.size(), 0);
    chk("B_addr_hold", bram_rd_addr, 20'h5C);

    // 16 words with a randomly stalling consumer.
    rnd_mode = 1'b1;
    clear_logs();
    pulse_start(20'h1000, 20'd16, t);
    wait_done(400, "C");
    rnd_mode = 1'b0;
    chk("C_nbeats", beat_data.size(), 16);
    if (beat_data.size() == 16) begin
      for (int k = 0; k < 16; k++) chk("C_data", beat_data[k], 'h400 + k);
    end

    // Address wrap at the top of the 20-bit space.
    clear_logs();
    pulse_start(20'hFFFF8, 20'd4, t);
    wait_done(60, "D");
    chk("D_naddr", addr_log.size(), 4);
    chk("D_nbeats", beat_data.size(), 4);
    if (addr_log.size() == 4 && beat_data.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("D_addr", addr_log[k], d_addr[k]);
        chk("D_data", beat_data[k], d_data[k]);
      end
    end

    // Reset in the middle of a 10-word burst, then a fresh 2-word burst.
    clear_logs();
    pulse_start(20'h300, 20'd10, t);
    i = 0;
    while (beat_cyc.size() < 3 && i < 60) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("E_reached_3_beats", beat_cyc.size() >= 3, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    start = 1'b1;
    base_addr = 20'h500;
    num_words = 20'd2;
    t = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(60, "E");
    chk("E_nbeats", beat_data.size(), 2);
    chk("E_naddr", addr_log.size(), 2);
    if (beat_data.size() == 2 && addr_log.size() == 2) begin
      chk("E_data0", beat_data[0], 32'h140);
      chk("E_data1", beat_data[1], 32'h141);
      chk("E_addr0", addr_log[0], 20'h500);
      chk("E_addr1", addr_log[1], 20'h504);
    end
    chk("E_done_cyc", done_cyc.size() == 1 ? done_cyc[0] : -1, t + 5);

    // Start re-pulsed while busy must be ignored.
    rnd_mode = 1'b1;
    clear_logs();
    pulse_start(20'h800, 20'd6, t);
    @(posedge clk);
    #1;
    pulse_start(20'h900, 20'd3, t2);
    wait_done(300, "F");
    rnd_mode = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("F_nbeats", beat_data.size(), 6);
    chk("F_naddr", addr_log.size(), 6);
    chk("F_ndone", done_cyc.size(), 1);
    if (beat_data.size() == 6 && addr_log.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("F_data", beat_data[k], 'h200 + k);
        chk("F_addr", addr_log[k], 'h800 + 4 * k);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000 ns");
    $fatal(1, "watchdog");
  end

endmodule
